// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver FSM states and the
// configuration helpers used by the frame receiver.
package uart_pkg;

    localparam logic [2:0] PAR_NONE  = 3'd0;
    localparam logic [2:0] PAR_EVEN  = 3'd1;
    localparam logic [2:0] PAR_ODD   = 3'd2;
    localparam logic [2:0] PAR_MARK  = 3'd3;
    localparam logic [2:0] PAR_SPACE = 3'd4;

    localparam int unsigned MIN_DIVISOR = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_DONE
    } rx_state_t;

    function automatic logic parity_enabled(input logic [2:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD) ||
               (mode == PAR_MARK) || (mode == PAR_SPACE);
    endfunction

    function automatic logic parity_expected(input logic [2:0] mode, input logic data_xor);
        logic p;
        case (mode)
            PAR_EVEN: p = data_xor;
            PAR_ODD:  p = ~data_xor;
            PAR_MARK: p = 1'b1;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

    function automatic logic [3:0] clamp_bits(input logic [3:0] bits, input int unsigned max_bits);
        logic [3:0] r;
        if (bits < 4'd5)
            r = 4'd5;
        else if (32'(bits) > max_bits)
            r = 4'(max_bits);
        else
            r = bits;
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Baud down-counter: half-bit preload on start detection, then a strobe
// every div cycles while the receiver is inside a frame.
module uart_rx_bit_timer #(
    parameter int COUNTER_BITS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [COUNTER_BITS-1:0] div,
    input  logic                    load_half,
    input  logic                    run,
    output logic                    strobe
);

    logic [COUNTER_BITS-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load_half) begin
            cnt <= div >> 1;
        end else if (run) begin
            if (cnt == '0)
                cnt <= div - COUNTER_BITS'(1);
            else
                cnt <= cnt - COUNTER_BITS'(1);
        end
    end

    assign strobe = run && (cnt == '0);

endmodule

// File: rtl/uart_rx_frame.sv
// Runtime-configurable UART receiver with filtered mid-bit sampling,
// per-character error flags and a 1-entry AXI-Stream holding register.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int MAX_DATA_BITS = 9,
    parameter int COUNTER_BITS  = 16,
    parameter int FILTER_BITS   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [COUNTER_BITS-1:0]  cfg_counter_div,
    input  logic [3:0]               cfg_data_bits,
    input  logic [2:0]               cfg_parity,
    input  logic                     cfg_stop2,
    input  logic                     rxd,
    output logic [MAX_DATA_BITS-1:0] axis_data,
    output logic                     axis_valid,
    input  logic                     axis_ready,
    output logic                     axis_err_frame,
    output logic                     axis_err_parity,
    output logic                     axis_err_noise,
    output logic                     axis_break,
    output logic                     stat_overrun,
    input  logic                     stat_overrun_clr,
    output logic                     busy
);

    logic                     sync1, sync2;
    logic [FILTER_BITS-1:0]   hist;
    logic [FILTER_BITS:0]     win;
    logic                     filt_lo, filt_hi;

    rx_state_t                state, state_nx;
    logic                     start_det, strobe, run;

    logic [COUNTER_BITS-1:0]  div_q, div_eff, timer_div;
    logic [3:0]               nbits_q, bit_cnt, shamt;
    logic [2:0]               par_q;
    logic                     stop2_q;
    logic [MAX_DATA_BITS-1:0] sh, data_rj;
    logic                     noise_q, any_hi_q, par_err_q, frm_err_q, wait_hi_q;
    logic                     done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= '1;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
            hist  <= win[FILTER_BITS-1:0];
        end
    end

    // The live synchronizer output plus the history form the FILTER_BITS+1 window.
    assign win     = {hist, sync2};
    assign filt_lo = (win == '0);
    assign filt_hi = (win == '1);

    assign div_eff   = (cfg_counter_div < COUNTER_BITS'(MIN_DIVISOR)) ?
                       COUNTER_BITS'(MIN_DIVISOR) : cfg_counter_div;
    assign timer_div = start_det ? div_eff : div_q;
    assign run       = (state == ST_START) || (state == ST_DATA) || (state == ST_PARITY) ||
                       (state == ST_STOP1) || (state == ST_STOP2);

    uart_rx_bit_timer #(
        .COUNTER_BITS(COUNTER_BITS)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .div       (timer_div),
        .load_half (start_det),
        .run       (run),
        .strobe    (strobe)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        start_det = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!wait_hi_q && filt_lo) begin
                    state_nx  = ST_START;
                    start_det = 1'b1;
                end
            end
            ST_START:  if (strobe) state_nx = filt_lo ? ST_DATA : ST_IDLE;
            ST_DATA: begin
                if (strobe && (bit_cnt == nbits_q - 4'd1))
                    state_nx = parity_enabled(par_q) ? ST_PARITY : ST_STOP1;
            end
            ST_PARITY: if (strobe) state_nx = ST_STOP1;
            ST_STOP1:  if (strobe) state_nx = stop2_q ? ST_STOP2 : ST_DONE;
            ST_STOP2:  if (strobe) state_nx = ST_DONE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            nbits_q   <= 4'd5;
            par_q     <= PAR_NONE;
            stop2_q   <= 1'b0;
            sh        <= '0;
            bit_cnt   <= '0;
            noise_q   <= 1'b0;
            any_hi_q  <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            wait_hi_q <= 1'b0;
        end else if (start_det) begin
            div_q     <= div_eff;
            nbits_q   <= clamp_bits(cfg_data_bits, MAX_DATA_BITS);
            par_q     <= cfg_parity;
            stop2_q   <= cfg_stop2;
            sh        <= '0;
            bit_cnt   <= '0;
            noise_q   <= 1'b0;
            any_hi_q  <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            if (strobe && !filt_lo && !filt_hi)
                noise_q <= 1'b1;
            case (state)
                ST_DATA: begin
                    if (strobe) begin
                        sh       <= {filt_hi, sh[MAX_DATA_BITS-1:1]};
                        bit_cnt  <= bit_cnt + 4'd1;
                        any_hi_q <= any_hi_q | filt_hi;
                    end
                end
                ST_PARITY: begin
                    if (strobe) begin
                        any_hi_q  <= any_hi_q | filt_hi;
                        par_err_q <= filt_hi != parity_expected(par_q, ^sh);
                    end
                end
                ST_STOP1, ST_STOP2: begin
                    if (strobe) begin
                        any_hi_q <= any_hi_q | filt_hi;
                        if (!filt_hi)
                            frm_err_q <= 1'b1;
                    end
                end
                // A line still low here is a break; hold off re-arming until it idles.
                ST_DONE: wait_hi_q <= !filt_hi;
                ST_IDLE: if (filt_hi) wait_hi_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign done    = (state == ST_DONE);
    assign shamt   = 4'(MAX_DATA_BITS) - nbits_q;
    assign data_rj = sh >> shamt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            axis_data       <= '0;
            axis_valid      <= 1'b0;
            axis_err_frame  <= 1'b0;
            axis_err_parity <= 1'b0;
            axis_err_noise  <= 1'b0;
            axis_break      <= 1'b0;
            stat_overrun    <= 1'b0;
        end else begin
            if (done && (!axis_valid || axis_ready)) begin
                axis_data       <= data_rj;
                axis_valid      <= 1'b1;
                axis_err_frame  <= frm_err_q;
                axis_err_parity <= par_err_q;
                axis_err_noise  <= noise_q;
                axis_break      <= !any_hi_q;
            end else if (axis_valid && axis_ready) begin
                axis_valid <= 1'b0;
            end

            if (stat_overrun_clr)
                stat_overrun <= 1'b0;
            else if (done && axis_valid && !axis_ready)
                stat_overrun <= 1'b1;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed scenarios plus randomized
// frames scored against a bit-level frame model.
module tb_uart_rx_frame;

    typedef struct packed {
        logic [8:0] data;
        logic       fe;
        logic       pe;
        logic       ne;
        logic       brk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic [15:0] cfg_counter_div = 16'd16;
    logic [3:0]  cfg_data_bits = 4'd8;
    logic [2:0]  cfg_parity = 3'd0;
    logic        cfg_stop2 = 1'b0;
    logic        axis_ready;
    logic        stat_overrun_clr = 1'b0;
    logic [8:0]  axis_data;
    logic        axis_valid, axis_err_frame, axis_err_parity, axis_err_noise, axis_break;
    logic        stat_overrun, busy;

    int   n_checks = 0;
    int   n_errors = 0;
    int   beats = 0;
    int   ready_mode = 1;
    exp_t exp_q[$];

    uart_rx_frame #(
        .MAX_DATA_BITS(9),
        .COUNTER_BITS(16),
        .FILTER_BITS(3)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_counter_div  (cfg_counter_div),
        .cfg_data_bits    (cfg_data_bits),
        .cfg_parity       (cfg_parity),
        .cfg_stop2        (cfg_stop2),
        .rxd              (rxd),
        .axis_data        (axis_data),
        .axis_valid       (axis_valid),
        .axis_ready       (axis_ready),
        .axis_err_frame   (axis_err_frame),
        .axis_err_parity  (axis_err_parity),
        .axis_err_noise   (axis_err_noise),
        .axis_break       (axis_break),
        .stat_overrun     (stat_overrun),
        .stat_overrun_clr (stat_overrun_clr),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int clamp_nb(input int nb);
        return (nb < 5) ? 5 : ((nb > 9) ? 9 : nb);
    endfunction

    // Expected character derived purely from the transmitted bit sequence.
    function automatic exp_t model_frame(input bit bits[$], input int nb_cfg, input int par, input bit stop2);
        exp_t e;
        int   nb, idx, ones;
        bit   pbit, s1, s2, haspar;
        e    = '0;
        nb   = clamp_nb(nb_cfg);
        ones = 0;
        for (int i = 0; i < nb; i++) begin
            e.data[i] = bits[1+i];
            ones += int'(bits[1+i]);
        end
        idx    = 1 + nb;
        haspar = (par >= 1) && (par <= 4);
        pbit   = 1'b0;
        if (haspar) begin
            pbit = bits[idx];
            idx++;
        end
        case (par)
            1: e.pe = ((ones + int'(pbit)) % 2) != 0;
            2: e.pe = ((ones + int'(pbit)) % 2) == 0;
            3: e.pe = !pbit;
            4: e.pe = pbit;
            default: e.pe = 1'b0;
        endcase
        s1    = bits[idx];
        s2    = stop2 ? bits[idx+1] : 1'b1;
        e.fe  = !s1 || !s2;
        e.brk = (e.data == 9'd0) && !pbit && !s1 && !s2;
        e.ne  = 1'b0;
        return e;
    endfunction

    task automatic set_cfg(input int div, input int nb_cfg, input int par, input bit stop2);
        cfg_counter_div = 16'(div);
        cfg_data_bits   = 4'(nb_cfg);
        cfg_parity      = 3'(par);
        cfg_stop2       = stop2;
    endtask

    task automatic send_frame(input logic [8:0] data, input int nb_cfg, input int par, input bit stop2,
                              input bit bad_par, input bit bad_stop, input int div, input bit expect_it);
        bit bits[$];
        int nb, ones;
        bit p;
        set_cfg(div, nb_cfg, par, stop2);
        nb   = clamp_nb(nb_cfg);
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            bits.push_back(data[i]);
            ones += int'(data[i]);
        end
        if (par >= 1 && par <= 4) begin
            case (par)
                1: p = (ones % 2) == 1;
                2: p = (ones % 2) == 0;
                3: p = 1'b1;
                default: p = 1'b0;
            endcase
            bits.push_back(p ^ bad_par);
        end
        bits.push_back(!bad_stop);
        if (stop2) bits.push_back(1'b1);
        if (expect_it) exp_q.push_back(model_frame(bits, nb_cfg, par, stop2));
        foreach (bits[i]) begin
            rxd = bits[i];
            tick(div);
            if (i == 0)
                set_cfg($urandom_range(8, 40), $urandom_range(0, 15), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
        end
        rxd = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) tick(1);
        check_eq(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        axis_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 2)
                axis_ready = ($urandom_range(0, 3) != 0);
            else
                axis_ready = (ready_mode == 1);
        end
    end

    always @(negedge clk) begin
        if (!rst && axis_valid && axis_ready) begin
            exp_t e;
            beats++;
            check_eq("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("data", axis_data, e.data);
                check_eq("err_frame", axis_err_frame, e.fe);
                check_eq("err_parity", axis_err_parity, e.pe);
                check_eq("err_noise", axis_err_noise, e.ne);
                check_eq("break", axis_break, e.brk);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   b0, div, gap;
        bit   saw_busy, bad_stop;
        exp_t e;

        tick(3);
        check_eq("rst_valid", axis_valid, 0);
        check_eq("rst_data", axis_data, 0);
        check_eq("rst_flags", {axis_err_frame, axis_err_parity, axis_err_noise, axis_break}, 0);
        check_eq("rst_overrun", stat_overrun, 0);
        check_eq("rst_busy", busy, 0);
        rst = 1'b0;
        tick(20);

        // 8N1 0x55
        send_frame(9'h055, 8, 0, 1'b0, 1'b0, 1'b0, 16, 1'b1);
        drain("t1_drain");
        tick(16);
        check_eq("t1_busy_idle", busy, 0);

        // 7E1 0x41, good then bad parity
        send_frame(9'h041, 7, 1, 1'b0, 1'b0, 1'b0, 16, 1'b1);
        tick(8);
        send_frame(9'h041, 7, 1, 1'b0, 1'b1, 1'b0, 16, 1'b1);
        drain("t2_drain");

        // 4-cycle glitch on idle line
        tick(32);
        set_cfg(16, 8, 0, 1'b0);
        b0 = beats;
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        saw_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (busy) saw_busy = 1'b1;
            if (saw_busy && !busy) break;
        end
        check_eq("glitch_busy_seen", saw_busy, 1);
        check_eq("glitch_busy_clear", busy, 0);
        tick(48);
        check_eq("glitch_no_beat", beats, b0);
        check_eq("glitch_no_valid", axis_valid, 0);

        // Break: line low for three 8N2 frame times
        set_cfg(16, 8, 0, 1'b1);
        b0 = beats;
        e = '0;
        e.fe = 1'b1;
        e.brk = 1'b1;
        exp_q.push_back(e);
        rxd = 1'b0;
        tick(33 * 16);
        check_eq("break_one_beat", beats, b0 + 1);
        check_eq("break_not_rearmed", busy, 0);
        rxd = 1'b1;
        tick(64);
        check_eq("break_after_high", beats, b0 + 1);
        drain("break_drain");

        // Randomized frames with random back-pressure
        ready_mode = 2;
        for (int n = 0; n < 40; n++) begin
            div      = $urandom_range(9, 20);
            bad_stop = ($urandom_range(0, 5) == 0);
            gap      = bad_stop ? $urandom_range(div, 3 * div) : $urandom_range(0, 3 * div);
            send_frame(9'($urandom), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(5, 9),
                       $urandom_range(0, 4), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                       bad_stop, div, 1'b1);
            if (gap > 0) tick(gap);
        end
        drain("random_drain");
        ready_mode = 1;
        tick(4);
        check_eq("random_no_overrun", stat_overrun, 0);

        // Overrun with consumer stalled
        ready_mode = 0;
        tick(2);
        b0 = beats;
        send_frame(9'h0A5, 8, 0, 1'b0, 1'b0, 1'b0, 16, 1'b1);
        send_frame(9'h03C, 8, 0, 1'b0, 1'b0, 1'b0, 16, 1'b0);
        tick(32);
        check_eq("ovr_valid", axis_valid, 1);
        check_eq("ovr_held_data", axis_data, 9'h0A5);
        check_eq("ovr_sticky", stat_overrun, 1);
        stat_overrun_clr = 1'b1;
        tick(1);
        stat_overrun_clr = 1'b0;
        tick(1);
        check_eq("ovr_cleared", stat_overrun, 0);
        check_eq("ovr_still_held", axis_data, 9'h0A5);
        ready_mode = 1;
        drain("ovr_drain");
        tick(4);
        check_eq("ovr_one_beat", beats, b0 + 1);

        // Reset pulsed mid-DATA, then 0x81 in 9O1
        set_cfg(16, 9, 2, 1'b0);
        b0 = beats;
        rxd = 1'b0;
        tick(16);
        rxd = 1'b1;
        tick(16);
        rxd = 1'b0;
        tick(16);
        rst = 1'b1;
        rxd = 1'b1;
        tick(2);
        check_eq("midrst_valid", axis_valid, 0);
        check_eq("midrst_busy", busy, 0);
        rst = 1'b0;
        tick(32);
        send_frame(9'h081, 9, 2, 1'b0, 1'b0, 1'b0, 16, 1'b1);
        drain("midrst_drain");
        tick(4);
        check_eq("midrst_one_beat", beats, b0 + 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
